// File: rtl/xup_reduce_pipe.sv
// ---------------------------------------------------------------------------
// xup_reduce_pipe
//
// Purpose
//   Pipelined, parametrised successor to the fixed 6-input XUP NOR gate.
//   Each of CHANNELS independent WIDTH-bit input vectors is reduced to a
//   single bit with a run-time selectable function. Results travel through
//   a STAGES-deep registered pipeline with valid/ready handshakes on both
//   sides.
//
// Parameters
//   WIDTH     inputs per channel          (2..32, default 6)
//   CHANNELS  independent channels        (1..16, default 1)
//   STAGES    pipeline register stages    (1..4,  default 2)
//
// Ports
//   clk        in   1               rising-edge clock
//   reset      in   1               asynchronous assert, active-high reset
//   mode       in   3               function select, bound to the beat
//                                   000 AND, 001 NAND, 010 OR, 011 NOR,
//                                   100 XOR, 101 XNOR, 110/111 NOR
//   in_valid   in   1               input beat valid
//   in_ready   out  1               block accepts a beat this cycle
//   in_data    in   CHANNELS*WIDTH  channel c = in_data[c*WIDTH +: WIDTH]
//   out_valid  out  1               out_data valid (registered)
//   out_ready  in   1               downstream accepts out_data
//   out_data   out  CHANNELS        bit c = reduction of channel c
//   out_count  out  16              count of drained results
//
// Build option
//   XUP_REDUCE_COUNT_EN : when defined, out_count counts every
//   out_valid && out_ready handshake (wrapping 16-bit). When undefined the
//   port remains and is tied to zero; no counter is built.
// ---------------------------------------------------------------------------
module xup_reduce_pipe #(
  parameter int WIDTH    = 6,
  parameter int CHANNELS = 1,
  parameter int STAGES   = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [2:0]                mode,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [CHANNELS-1:0]       out_data,
  output logic [15:0]               out_count
);

  localparam logic [2:0] MODE_AND  = 3'b000;
  localparam logic [2:0] MODE_NAND = 3'b001;
  localparam logic [2:0] MODE_OR   = 3'b010;
  localparam logic [2:0] MODE_XOR  = 3'b100;
  localparam logic [2:0] MODE_XNOR = 3'b101;

  // Per-channel reduction. Anything not explicitly decoded (011, 110, 111)
  // falls through to NOR, which preserves the behaviour of the legacy gate.
  function automatic logic [CHANNELS-1:0] reduce_f(
    input logic [CHANNELS*WIDTH-1:0] d,
    input logic [2:0]                m
  );
    logic [CHANNELS-1:0] r;
    logic [WIDTH-1:0]    v;
    r = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      v = d[c*WIDTH +: WIDTH];
      case (m)
        MODE_AND:  r[c] = &v;
        MODE_NAND: r[c] = ~&v;
        MODE_OR:   r[c] = |v;
        MODE_XOR:  r[c] = ^v;
        MODE_XNOR: r[c] = ~^v;
        default:   r[c] = ~|v;
      endcase
    end
    return r;
  endfunction

  logic [STAGES-1:0]   vld_q;
  logic [STAGES-1:0]   vld_d;
  logic [CHANNELS-1:0] data_q [STAGES];
  logic [CHANNELS-1:0] data_d [STAGES];
  logic [STAGES-1:0]   adv;
  logic                full;

  // Ready chain. A stage may advance when the output drains or when any
  // stage at or after it is empty; the running AND from the last stage
  // downward expresses "everything from here to the output is occupied".
  // Built this way so no bit of adv depends on another bit of adv.
  always_comb begin
    adv  = '0;
    full = 1'b1;
    for (int k = STAGES - 1; k >= 0; k--) begin
      full   = full & vld_q[k];
      adv[k] = out_ready | ~full;
    end
  end

  assign in_ready = adv[0];

  // Stage 0 captures the reduction; data is only loaded on a real accept,
  // so undriven in_data during idle cycles never reaches the registers.
  // Later stages shift forward whenever they are allowed to advance, which
  // lets bubbles close up even while the output is stalled.
  always_comb begin
    vld_d = vld_q;
    for (int k = 0; k < STAGES; k++) begin
      data_d[k] = data_q[k];
    end
    if (adv[0]) begin
      vld_d[0] = in_valid;
      if (in_valid) begin
        data_d[0] = reduce_f(in_data, mode);
      end
    end
    for (int k = 1; k < STAGES; k++) begin
      if (adv[k]) begin
        vld_d[k]  = vld_q[k-1];
        data_d[k] = data_q[k-1];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_q <= '0;
      for (int k = 0; k < STAGES; k++) begin
        data_q[k] <= '0;
      end
    end else begin
      vld_q <= vld_d;
      for (int k = 0; k < STAGES; k++) begin
        data_q[k] <= data_d[k];
      end
    end
  end

  assign out_valid = vld_q[STAGES-1];
  assign out_data  = data_q[STAGES-1];

`ifdef XUP_REDUCE_COUNT_EN
  logic [15:0] count_q;
  logic [15:0] count_d;

  // Natural 16-bit wrap gives 0xFFFF -> 0x0000.
  always_comb begin
    count_d = count_q;
    if (out_valid && out_ready) begin
      count_d = count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= 16'h0000;
    end else begin
      count_q <= count_d;
    end
  end

  assign out_count = count_q;
`else
  assign out_count = 16'h0000;
`endif

endmodule
